// File: rtl/stopwatch_tick_controller.sv
// stopwatch_tick_controller: run/pause/clear sequencer and tick-rate prescaler; optional lap hold via LAP_FREEZE_EN
module stopwatch_tick_controller #(
  parameter int CNT_W      = 28,
  parameter int NORMAL_DIV = 500000,
  parameter int SLOW_DIV   = 100000000
) (
  input  logic clock_in,
  input  logic reset,
  input  logic start_stop,
  input  logic clear,
  input  logic slow_mode,
`ifdef LAP_FREEZE_EN
  input  logic lap,
  output logic display_hold,
`endif
  output logic tick,
  output logic clear_out,
  output logic running,
  output logic rate_slow
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [CNT_W-1:0] NORM_M1 = CNT_W'(NORMAL_DIV - 1);
  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(SLOW_DIV - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d, clear_out_q, clear_out_d, running_q, rate_slow_q, rate_slow_d;
  logic wrap;
  // >= rather than == so a count left above a shorter divisor still wraps
  assign wrap = cnt_q >= (rate_slow_q ? SLOW_M1 : NORM_M1);
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tick_d      = 1'b0;
    clear_out_d = 1'b0;
    rate_slow_d = rate_slow_q;
    if (clear) begin
      state_d     = IDLE;
      cnt_d       = '0;
      clear_out_d = 1'b1;
      rate_slow_d = (state_q == IDLE) ? slow_mode : rate_slow_q;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d       = '0;
          rate_slow_d = slow_mode;
          state_d     = start_stop ? RUN : IDLE;
        end
        RUN: begin
          cnt_d       = wrap ? '0 : cnt_q + CNT_W'(1);
          tick_d      = wrap;
          rate_slow_d = wrap ? slow_mode : rate_slow_q;
          state_d     = start_stop ? PAUSE : RUN;
        end
        PAUSE:   state_d = start_stop ? RUN : PAUSE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      clear_out_q <= 1'b0;
      running_q   <= 1'b0;
      rate_slow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      clear_out_q <= clear_out_d;
      running_q   <= (state_d == RUN);
      rate_slow_q <= rate_slow_d;
    end
  end
  assign tick      = tick_q;
  assign clear_out = clear_out_q;
  assign running   = running_q;
  assign rate_slow = rate_slow_q;
`ifdef LAP_FREEZE_EN
  logic hold_q, hold_d;
  assign hold_d = clear ? 1'b0 : (state_q == RUN && lap) ? ~hold_q : hold_q;
  always_ff @(posedge clock_in) begin
    if (reset) hold_q <= 1'b0;
    else hold_q <= hold_d;
  end
  assign display_hold = hold_q;
`endif
endmodule

// File: tb/tb_stopwatch_tick_controller.sv
// tb_stopwatch_tick_controller: directed checks of cadence, pause, rate change, clear and reset
module tb_stopwatch_tick_controller;
  logic clock_in = 1'b0, reset = 1'b0, start_stop = 1'b0, clear = 1'b0, slow_mode = 1'b0;
  logic tick, clear_out, running, rate_slow;
  int total = 0, passed = 0, failed = 0;
`ifdef LAP_FREEZE_EN
  logic lap = 1'b0, display_hold;
`endif
  stopwatch_tick_controller #(.CNT_W(4), .NORMAL_DIV(4), .SLOW_DIV(10)) dut (
    .clock_in(clock_in), .reset(reset), .start_stop(start_stop), .clear(clear),
    .slow_mode(slow_mode),
`ifdef LAP_FREEZE_EN
    .lap(lap), .display_hold(display_hold),
`endif
    .tick(tick), .clear_out(clear_out), .running(running), .rate_slow(rate_slow));
  always #5 clock_in = ~clock_in;
  task automatic step();
    @(posedge clock_in);
    #1;
  endtask
  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic expect_ticks(input string tag, input int n, input int first, input int period);
    for (int i = 1; i <= n; i++) begin
      step();
      chk(tag, tick, (i >= first) && ((i - first) % period == 0));
    end
  endtask
  initial begin
    reset = 1'b1;
    step();
    chk("rst_tick", tick, 1'b0);
    chk("rst_clr", clear_out, 1'b0);
    chk("rst_run", running, 1'b0);
    chk("rst_rate", rate_slow, 1'b0);
`ifdef LAP_FREEZE_EN
    chk("rst_hold", display_hold, 1'b0);
`endif
    reset = 1'b0;
    step();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    chk("run_c3", running, 1'b1);
    chk("tick_c3", tick, 1'b0);
    expect_ticks("cadence", 12, 4, 4);
    chk("rate_norm", rate_slow, 1'b0);
    step();
    chk("c16_tick", tick, 1'b0);
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    chk("paused", running, 1'b0);
    expect_ticks("pause_quiet", 6, 99, 1);
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    chk("resumed", running, 1'b1);
    expect_ticks("resume", 6, 2, 4);
    step();
    chk("mid_tick", tick, 1'b0);
    slow_mode = 1'b1;
    step();
    chk("defer_rate0", rate_slow, 1'b0);
    step();
    chk("defer_rate1", rate_slow, 1'b0);
    chk("defer_tick", tick, 1'b0);
    step();
    chk("wrap_tick", tick, 1'b1);
    chk("wrap_rate", rate_slow, 1'b1);
    expect_ticks("slow", 20, 10, 10);
    slow_mode = 1'b0;
    step();
    chk("slow_hold", rate_slow, 1'b1);
    expect_ticks("slow_last", 9, 9, 10);
    chk("back_norm", rate_slow, 1'b0);
    step();
    step();
    clear = 1'b1;
    start_stop = 1'b1;
    step();
    clear = 1'b0;
    start_stop = 1'b0;
    chk("clr_pulse", clear_out, 1'b1);
    chk("clr_run", running, 1'b0);
    chk("clr_tick", tick, 1'b0);
    step();
    chk("clr_once", clear_out, 1'b0);
    chk("clr_notick", tick, 1'b0);
    chk("clr_idle", running, 1'b0);
    expect_ticks("idle_quiet", 4, 99, 1);
    slow_mode = 1'b1;
    step();
    chk("idle_rate1", rate_slow, 1'b1);
    slow_mode = 1'b0;
    step();
    chk("idle_rate0", rate_slow, 1'b0);
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    chk("rerun", running, 1'b1);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_tick", tick, 1'b0);
    chk("mrst_run", running, 1'b0);
    chk("mrst_clr", clear_out, 1'b0);
    chk("mrst_rate", rate_slow, 1'b0);
    step();
    chk("mrst_quiet", tick, 1'b0);
    start_stop = 1'b1;
    step();
    chk("held_run", running, 1'b1);
    step();
    chk("held_pause", running, 1'b0);
    step();
    start_stop = 1'b0;
    chk("held_run2", running, 1'b1);
`ifdef LAP_FREEZE_EN
    lap = 1'b1;
    step();
    lap = 1'b0;
    chk("lap_on", display_hold, 1'b1);
    step();
    chk("lap_cnt3", tick, 1'b0);
    step();
    chk("lap_tick", tick, 1'b1);
    chk("lap_still", display_hold, 1'b1);
    lap = 1'b1;
    step();
    lap = 1'b0;
    chk("lap_off", display_hold, 1'b0);
    lap = 1'b1;
    step();
    lap = 1'b0;
    chk("lap_on2", display_hold, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("lap_clr", display_hold, 1'b0);
    lap = 1'b1;
    step();
    lap = 1'b0;
    chk("lap_idle", display_hold, 1'b0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
